// File: rtl/branch_update_queue.sv
// Purpose : in-order retirement queue that turns out-of-order branch resolutions into predictor updates.
// Latency : resolve sampled at edge N -> anUpdate_o high in cycle N+2; one retire per cycle.
// Backpressure: alloc_ready_o = !full (a same-cycle retire does not free a slot); a refused alloc is dropped.
//
// Ports:
//   clk_i, reset_n_i                        clock, synchronous active-low reset
//   alloc_valid_i/idx_i/pred_i              fetch-side allocation of a branch entry
//   alloc_ready_o, alloc_tag_o              slot available / tag (tail pointer) the allocation receives
//   resolve_valid_i/tag_i/taken_i           execute-side outcome, any order
//   flush_i                                 discard every in-flight entry, pointers back to 0
//   anUpdate_o, branchAddrWrite_o, brTaken_o, mispredict_o   registered predictor update
//   count_o                                 number of valid entries (0..DEPTH)
//   stat_updates_o, stat_mispred_o          saturating event counters when BRANCH_UPDATE_QUEUE_STATS_EN
//                                           is defined, tied to 0 otherwise
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             alloc_valid_i,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  logic             alloc_pred_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             resolve_valid_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_taken_i,
    input  logic             flush_i,
    output logic             anUpdate_o,
    output logic [IDX_W-1:0] branchAddrWrite_o,
    output logic             brTaken_o,
    output logic             mispredict_o,
    output logic [TAG_W:0]   count_o,
    output logic [15:0]      stat_updates_o,
    output logic [15:0]      stat_mispred_o
);

    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_resolved;
    logic [DEPTH-1:0] ent_pred;
    logic [DEPTH-1:0] ent_taken;
    logic [IDX_W-1:0] ent_idx [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   head;
    logic [TAG_W:0]   tail;
    logic [TAG_W-1:0] head_lo;
    logic [TAG_W-1:0] tail_lo;
    logic             full;
    logic             do_alloc;
    logic             do_resolve;
    logic             do_retire;

    assign head_lo = head[TAG_W-1:0];
    assign tail_lo = tail[TAG_W-1:0];
    assign full    = (head[TAG_W] != tail[TAG_W]) && (head_lo == tail_lo);

    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_lo;
    assign count_o       = tail - head;

    assign do_alloc   = alloc_valid_i && !full;
    // Only registered valid/resolved bits are consulted: a branch allocated this
    // cycle cannot be resolved yet, and the first outcome of an entry wins.
    assign do_resolve = resolve_valid_i && ent_valid[resolve_tag_i] && !ent_resolved[resolve_tag_i];
    // Retire looks at registered state only, so a resolve to the head takes
    // effect in the following cycle (no bypass).
    assign do_retire  = ent_valid[head_lo] && ent_resolved[head_lo];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ent_valid         <= '0;
            ent_resolved      <= '0;
            head              <= '0;
            tail              <= '0;
            anUpdate_o        <= 1'b0;
            branchAddrWrite_o <= '0;
            brTaken_o         <= 1'b0;
            mispredict_o      <= 1'b0;
        end else if (flush_i) begin
            ent_valid    <= '0;
            head         <= '0;
            tail         <= '0;
            anUpdate_o   <= 1'b0;
            mispredict_o <= 1'b0;
        end else begin
            anUpdate_o   <= do_retire;
            mispredict_o <= do_retire && (ent_taken[head_lo] != ent_pred[head_lo]);
            if (do_retire) begin
                ent_valid[head_lo] <= 1'b0;
                head               <= head + PTR_ONE;
                branchAddrWrite_o  <= ent_idx[head_lo];
                brTaken_o          <= ent_taken[head_lo];
            end
            // The resolve target is valid and the alloc target (tail, not full)
            // is invalid, so these never hit the same slot; the retiring head is
            // already resolved, so a resolve cannot touch it either.
            if (do_resolve) begin
                ent_resolved[resolve_tag_i] <= 1'b1;
                ent_taken[resolve_tag_i]    <= resolve_taken_i;
            end
            if (do_alloc) begin
                ent_valid[tail_lo]    <= 1'b1;
                ent_resolved[tail_lo] <= 1'b0;
                ent_idx[tail_lo]      <= alloc_idx_i;
                ent_pred[tail_lo]     <= alloc_pred_i;
                ent_taken[tail_lo]    <= 1'b0;
                tail                  <= tail + PTR_ONE;
            end
        end
    end

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    // Counters observe the registered strobes and survive flush.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
        end else begin
            if (anUpdate_o && (stat_updates_o != 16'hFFFF)) begin
                stat_updates_o <= stat_updates_o + 16'd1;
            end
            if (mispredict_o && (stat_mispred_o != 16'hFFFF)) begin
                stat_mispred_o <= stat_mispred_o + 16'd1;
            end
        end
    end
`else
    assign stat_updates_o = 16'd0;
    assign stat_mispred_o = 16'd0;
`endif

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Write-side companion to the 32-entry 2-bit branch prediction table.
- Records each fetched branch's table index and prediction in program order.
- Accepts out-of-order resolutions from execute.
- Retires resolved branches strictly in order. Each retirement drives one update (anUpdate/branchAddrWrite/brTaken) into the predictor and flags mispredictions.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of 2, minimum 2.
- TAG_W, 3, entry tag width; equals log2(DEPTH).
- IDX_W, 5, predictor table index width (32 entries).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  reset, synchronous, active-low.
- alloc_valid_i  in  1  fetch requests an entry for a new branch.
- alloc_idx_i  in  IDX_W  predictor index used at fetch.
- alloc_pred_i  in  1  prediction read at fetch (1 = taken).
- alloc_ready_o  out  1  entry available; combinational, equals !full.
- alloc_tag_o  out  TAG_W  tag the current allocation receives; equals the tail pointer.
- resolve_valid_i  in  1  execute reports a branch outcome.
- resolve_tag_i  in  TAG_W  tag of the resolved branch.
- resolve_taken_i  in  1  actual outcome.
- flush_i  in  1  discard all in-flight entries.
- anUpdate_o  out  1  registered predictor update strobe.
- branchAddrWrite_o  out  IDX_W  registered predictor write index.
- brTaken_o  out  1  registered actual outcome for the update.
- mispredict_o  out  1  registered pulse, coincident with anUpdate_o, when outcome != prediction.
- count_o  out  TAG_W+1  number of valid entries.

Behaviour:
- Storage: circular buffer of DEPTH entries. Each entry holds {valid, resolved, idx, pred, taken}.
- Pointers: head and tail are TAG_W+1 bits; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = (low bits equal, MSBs differ).
- Reset (reset_n_i == 0 at an edge):
  - head, tail and count cleared; all valid bits cleared.
  - anUpdate_o, branchAddrWrite_o, brTaken_o and mispredict_o are all 0.
  - alloc_ready_o is 1 and alloc_tag_o is 0.
- Allocate: alloc_valid_i && alloc_ready_o writes entry[tail] = {1, 0, alloc_idx_i, alloc_pred_i, 0}, then tail increments.
  - alloc_valid_i while full is dropped with no state change.
  - alloc_ready_o is not relieved by a same-cycle retire; a full queue refuses allocation even if retiring.
- Resolve: resolve_valid_i with entry[tag] valid and not yet resolved sets resolved = 1 and taken = resolve_taken_i.
  - Resolve to an invalid entry is ignored.
  - Resolve to an already-resolved entry is ignored; the first outcome wins.
- Retire: evaluated each cycle from registered state only. Resolve-to-head has no same-cycle bypass.
  - If entry[head] is valid and resolved: clear its valid bit, increment head, and at the same edge register anUpdate_o = 1, branchAddrWrite_o = idx, brTaken_o = taken, mispredict_o = (taken != pred).
  - Otherwise anUpdate_o and mispredict_o are 0 next cycle; branchAddrWrite_o and brTaken_o hold their previous values.
  - At most one retire per cycle.
- Latency: resolve sampled at edge N, retire decision in cycle N+1, anUpdate_o high in cycle N+2. Back-to-back resolved entries retire on consecutive cycles.
- Simultaneous events, same cycle:
  - alloc + retire: both occur; count unchanged.
  - alloc + resolve of the just-allocated tag: the resolve is ignored, because the entry is not yet valid.
- count_o = tail - head (wrap-aware). Range 0..DEPTH.
- Flush (flush_i == 1 at an edge), takes priority over alloc, resolve and retire in that cycle:
  - all valid bits cleared; head = tail = 0.
  - anUpdate_o and mispredict_o are 0 next cycle.
- Reset mid-operation behaves as flush and also clears the registered output fields.

Optional Feature:
- Macro: BRANCH_UPDATE_QUEUE_STATS_EN.
- Defined: adds outputs stat_updates_o[15:0] and stat_mispred_o[15:0].
  - Saturating counters, incremented on each anUpdate_o and mispredict_o pulse respectively.
  - Cleared by reset only, not by flush.
- Undefined: both ports exist and are tied to 0; no counter flops.

Test Plan:
- Reset then idle: after reset_n_i deasserts -> alloc_ready_o=1, alloc_tag_o=0, count_o=0, anUpdate_o=0 for 10 cycles.
- In-order single branch: alloc idx=4 pred=0 (tag 0), resolve tag 0 taken=1 one cycle later -> two cycles after resolve, anUpdate_o=1, branchAddrWrite_o=4, brTaken_o=1, mispredict_o=1 for exactly one cycle.
- Out-of-order resolution: alloc idx 15, 27, 6 (tags 0, 1, 2); resolve tags 2, 1, then 0, all matching their predictions -> updates emitted in order 15, 27, 6 on consecutive cycles; mispredict_o stays 0.
- Full and wrap: 8 allocs -> alloc_ready_o=0, count_o=8; 9th alloc is dropped. Resolve and retire tag 0 -> next alloc receives tag 0 (wrap); count_o returns to 8.
- Flush: 3 entries with 2 resolved, assert flush_i together with resolve tag 2 -> no anUpdate_o afterwards, count_o=0, alloc_tag_o=0.
- Duplicate resolve: resolve tag 0 taken=1, then tag 0 taken=0 -> brTaken_o=1 at retire.
